ctrl_seq: RTL



---
 rtl/ctrl_pkg.sv | 78 +++++++
 rtl/mdu_seq.sv | 72 +++++++
 rtl/ctrl_seq.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared opcodes, control-field encodings and decode helpers for ctrl_seq.
// The M-extension is enabled by defining CTRL_MDU_EN.
package ctrl_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam int GPIO_STRIDE = 4;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000, ALU_OR   = 4'b0001, ALU_XOR  = 4'b0010,
        ALU_ADD  = 4'b0011, ALU_SUB  = 4'b0100, ALU_MUL  = 4'b0101,
        ALU_MULH = 4'b0110, ALU_MULU = 4'b0111, ALU_SLL  = 4'b1000,
        ALU_SRL  = 4'b1001, ALU_SRA  = 4'b1010, ALU_SLT  = 4'b1100,
        ALU_SLTU = 4'b1101, ALU_DIV  = 4'b1110, ALU_REM  = 4'b1111
    } aluop_t;

    typedef enum logic [1:0] {
        SRC_RS2 = 2'b00, SRC_IMM12 = 2'b01, SRC_IMM20 = 2'b10
    } alusrc_t;

    typedef enum logic [1:0] {
        SEL_NONE = 2'b00, SEL_IMM20 = 2'b01, SEL_ALU = 2'b10, SEL_GPIO = 2'b11
    } regsel_t;

    typedef enum logic {
        MDU_IDLE = 1'b0, MDU_BUSY = 1'b1
    } mdu_state_t;

    typedef struct packed {
        alusrc_t    alusrc;
        logic       regwrite;
        regsel_t    regsel;
        aluop_t     aluop;
        logic [2:0] funct3;
        logic       illegal;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_ZERO = '{alusrc: SRC_RS2, regwrite: 1'b0, regsel: SEL_NONE,
                                         aluop: ALU_AND, funct3: 3'b000, illegal: 1'b0};

    // funct3 -> ALU op for the base integer group (shared by R-type and I-type)
    function automatic aluop_t base_aluop(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            3'b111:  return ALU_AND;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic aluop_t mdu_aluop(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_MUL;
            3'b001:  return ALU_MULH;
            3'b010:  return ALU_MULU;
            3'b011:  return ALU_MULU;
            3'b100:  return ALU_DIV;
            3'b101:  return ALU_DIV;
            3'b110:  return ALU_REM;
            3'b111:  return ALU_REM;
            default: return ALU_MUL;
        endcase
    endfunction

endpackage

// File: rtl/mdu_seq.sv
// Divide sequencer: tracks EX occupancy of an iterative divide and pulses start.
// Instantiated by ctrl_seq only when CTRL_MDU_EN is defined.
module mdu_seq
    import ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic div_req,
    output logic busy,
    output logic last,
    output logic start
);

    localparam int CW = $clog2(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_CYCLES - 1);

    mdu_state_t    state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic          start_r, start_s;

    // Next state: a request in IDLE or on the final BUSY cycle (re)loads the counter
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        start_s = 1'b0;
        case (state_r)
            MDU_IDLE: begin
                if (div_req) begin
                    state_s = MDU_BUSY;
                    cnt_s   = CNT_LOAD;
                    start_s = 1'b1;
                end else begin
                    state_s = MDU_IDLE;
                end
            end
            MDU_BUSY: begin
                if (cnt_r != {CW{1'b0}}) begin
                    cnt_s = cnt_r - CW'(1);
                end else if (div_req) begin
                    cnt_s   = CNT_LOAD;
                    start_s = 1'b1;
                end else begin
                    state_s = MDU_IDLE;
                end
            end
            default: begin
                state_s = MDU_IDLE;
                cnt_s   = {CW{1'b0}};
            end
        endcase
    end

    // State, counter and start-pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= MDU_IDLE;
            cnt_r   <= {CW{1'b0}};
            start_r <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            start_r <= start_s;
        end
    end

    assign busy  = (state_r == MDU_BUSY);
    assign last  = busy && (cnt_r == {CW{1'b0}});
    assign start = start_r;

endmodule

// File: rtl/ctrl_seq.sv
// EX-stage control word register with GPIO CSR decode and divide stall sequencing.
// Define CTRL_MDU_EN to enable the M-extension decode and the divide FSM.
module ctrl_seq
    import ctrl_pkg::*;
#(
    parameter int          N_GPIO     = 2,
    parameter int          DIV_CYCLES = 32,
    parameter logic [11:0] CSR_BASE   = 12'hF00,
    localparam int         RSEL_W     = (N_GPIO > 1) ? $clog2(N_GPIO) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_ID,
    input  logic [6:0]        op,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [11:0]       imm12,
    output logic              stall_F,
    output logic [1:0]        alusrc_EX,
    output logic              regwrite_EX,
    output logic [1:0]        regsel_EX,
    output logic [3:0]        aluop_EX,
    output logic [2:0]        funct3_EX,
    output logic [N_GPIO-1:0] gpio_we_EX,
    output logic [RSEL_W-1:0] gpio_rsel_EX,
    output logic              mdu_start,
    output logic              illegal_EX
);

    ctrl_word_t        dec_s, word_r;
    logic [N_GPIO-1:0] we_s, we_r;
    logic [RSEL_W-1:0] rsel_s, rsel_r;
    logic              legal_s;
    logic              stall_s;
`ifdef CTRL_MDU_EN
    logic              div_s;
    logic              busy_s;
    logic              last_s;
    logic              start_s;
`endif

    // Decode the ID instruction; anything unrecognised collapses to an illegal zero word
    always_comb begin
        dec_s   = CTRL_ZERO;
        we_s    = {N_GPIO{1'b0}};
        rsel_s  = {RSEL_W{1'b0}};
        legal_s = 1'b0;
`ifdef CTRL_MDU_EN
        div_s   = 1'b0;
`endif
        if (valid_ID) begin
            dec_s.funct3   = funct3;
            dec_s.regwrite = 1'b1;
            case (op)
                OP_RTYPE: begin
                    dec_s.alusrc = SRC_RS2;
                    dec_s.regsel = SEL_ALU;
                    if (funct7 == F7_BASE) begin
                        dec_s.aluop = base_aluop(funct3);
                        legal_s     = 1'b1;
                    end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                        dec_s.aluop = ALU_SUB;
                        legal_s     = 1'b1;
                    end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                        dec_s.aluop = ALU_SRA;
                        legal_s     = 1'b1;
`ifdef CTRL_MDU_EN
                    end else if (funct7 == F7_MULDIV) begin
                        // rd is written only on the final divide cycle, not at issue
                        dec_s.aluop    = mdu_aluop(funct3);
                        dec_s.regwrite = ~funct3[2];
                        div_s          = funct3[2];
                        legal_s        = 1'b1;
`endif
                    end else begin
                        legal_s = 1'b0;
                    end
                end
                OP_ITYPE: begin
                    dec_s.alusrc = SRC_IMM12;
                    dec_s.regsel = SEL_ALU;
                    dec_s.aluop  = base_aluop(funct3);
                    if (funct3 == 3'b001 || funct3 == 3'b101) begin
                        if (imm12[11:5] == F7_BASE) begin
                            legal_s = 1'b1;
                        end else if (funct3 == 3'b101 && imm12[11:5] == F7_ALT) begin
                            dec_s.aluop = ALU_SRA;
                            legal_s     = 1'b1;
                        end else begin
                            legal_s = 1'b0;
                        end
                    end else begin
                        legal_s = 1'b1;
                    end
                end
                OP_LUI: begin
                    dec_s.alusrc = SRC_IMM20;
                    dec_s.regsel = SEL_IMM20;
                    dec_s.aluop  = ALU_AND;
                    legal_s      = 1'b1;
                end
                OP_SYSTEM: begin
                    dec_s.regsel = SEL_GPIO;
                    if (funct3 == F3_CSRRW) begin
                        // Channel k: input at BASE+4k, output at BASE+2+4k
                        for (int k = 0; k < N_GPIO; k++) begin
                            if (imm12 == CSR_BASE + 12'(GPIO_STRIDE * k)) begin
                                rsel_s  = RSEL_W'(k);
                                legal_s = 1'b1;
                            end else if (imm12 == CSR_BASE + 12'd2 + 12'(GPIO_STRIDE * k)) begin
                                we_s[k] = 1'b1;
                                legal_s = 1'b1;
                            end else begin
                                we_s[k] = we_s[k];
                            end
                        end
                    end else begin
                        legal_s = 1'b0;
                    end
                end
                default: legal_s = 1'b0;
            endcase
            if (!legal_s) begin
                dec_s         = CTRL_ZERO;
                dec_s.illegal = 1'b1;
                we_s          = {N_GPIO{1'b0}};
                rsel_s        = {RSEL_W{1'b0}};
`ifdef CTRL_MDU_EN
                div_s         = 1'b0;
`endif
            end else begin
                dec_s.illegal = 1'b0;
            end
        end else begin
            dec_s = CTRL_ZERO;
        end
    end

`ifdef CTRL_MDU_EN
    mdu_seq #(.DIV_CYCLES(DIV_CYCLES)) u_mdu_seq (
        .clk     (clk),
        .rst_n   (rst_n),
        .div_req (div_s & ~stall_s),
        .busy    (busy_s),
        .last    (last_s),
        .start   (start_s)
    );
    assign stall_s     = busy_s & ~last_s;
    assign mdu_start   = start_s;
    assign regwrite_EX = word_r.regwrite | last_s;
`else
    assign stall_s     = 1'b0;
    assign mdu_start   = 1'b0;
    assign regwrite_EX = word_r.regwrite;
`endif

    // EX control word register; held while a divide occupies EX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_r <= CTRL_ZERO;
            we_r   <= {N_GPIO{1'b0}};
            rsel_r <= {RSEL_W{1'b0}};
        end else if (!stall_s) begin
            word_r <= dec_s;
            we_r   <= we_s;
            rsel_r <= rsel_s;
        end else begin
            word_r <= word_r;
            we_r   <= we_r;
            rsel_r <= rsel_r;
        end
    end

    assign stall_F      = stall_s;
    assign alusrc_EX    = word_r.alusrc;
    assign regsel_EX    = word_r.regsel;
    assign aluop_EX     = word_r.aluop;
    assign funct3_EX    = word_r.funct3;
    assign illegal_EX   = word_r.illegal;
    assign gpio_we_EX   = we_r;
    assign gpio_rsel_EX = rsel_r;

endmodule
